// File: rtl/dice_reader.sv
// ============================================================================
//  Module   : dice_reader
//  Brief    : Waits for a dice roll to settle, latches the result, drives the
//             pip LEDs, keeps score/roll counters and offers a valid/ack handshake.
//             Optional macro DICE_READER_DOUBLE_BONUS_EN adds a repeated-roll
//             double-score bonus and a `bonus` output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_reader #(
    parameter int SETTLE_CYC = 4,
    parameter int SCORE_W    = 8,
    parameter int ROLL_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    input  logic               ack,
    output logic [2:0]         result,
    output logic [6:0]         pips,
    output logic               valid,
    output logic               error,
    output logic [SCORE_W-1:0] score,
    output logic [ROLL_W-1:0]  rolls
`ifdef DICE_READER_DOUBLE_BONUS_EN
    ,
    output logic               bonus
`endif
);

    localparam int                 c_CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROLLING = 2'd1,
        S_SETTLE  = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_ref;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_load_ref;
    logic                 w_cnt_inc;
    logic                 w_report;
    logic                 w_ack;
    logic                 w_ok;
    logic                 w_dbl;
    logic [3:0]           w_add;
    logic [SCORE_W+3:0]   w_sum;
    logic [SCORE_W-1:0]   w_score_nxt;

    function automatic logic [6:0] pip_of(input logic [2:0] v);
        case (v)
            3'd1:    pip_of = 7'h08;
            3'd2:    pip_of = 7'h41;
            3'd3:    pip_of = 7'h49;
            3'd4:    pip_of = 7'h63;
            3'd5:    pip_of = 7'h6B;
            3'd6:    pip_of = 7'h77;
            default: pip_of = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_ref  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_report    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (button) w_state_nxt = S_ROLLING;
            end
            S_ROLLING: begin
                if (!button) begin
                    w_state_nxt = S_SETTLE;
                    w_load_ref  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (button) begin
                    w_state_nxt = S_ROLLING;
                end else if (throw != r_ref) begin
                    w_load_ref = 1'b1;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_REPORT;
                    w_report    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_REPORT: begin
                // A new press is ignored until the current result is taken.
                if (ack) begin
                    w_state_nxt = S_IDLE;
                    w_ack       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ok = (r_ref != 3'd0) && (r_ref != 3'd7);

`ifdef DICE_READER_DOUBLE_BONUS_EN
    logic [2:0] r_prev;

    assign w_dbl = w_ok && (r_ref == r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 3'd0;
            bonus  <= 1'b0;
        end else if (w_report) begin
            r_prev <= w_ok ? r_ref : 3'd0;
            bonus  <= w_dbl;
        end else if (w_ack) begin
            bonus  <= 1'b0;
        end
    end
`else
    assign w_dbl = 1'b0;
`endif

    assign w_add       = w_dbl ? {r_ref, 1'b0} : {1'b0, r_ref};
    assign w_sum       = {4'd0, score} + (SCORE_W + 4)'(w_add);
    assign w_score_nxt = (w_sum > (SCORE_W + 4)'(c_SCORE_MAX)) ? c_SCORE_MAX : w_sum[SCORE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref  <= 3'd0;
            r_cnt  <= '0;
            result <= 3'd0;
            pips   <= 7'h00;
            valid  <= 1'b0;
            error  <= 1'b0;
            score  <= '0;
            rolls  <= '0;
        end else begin
            if (w_load_ref) begin
                r_ref <= throw;
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_report) begin
                result <= r_ref;
                valid  <= 1'b1;
                error  <= ~w_ok;
                pips   <= w_ok ? pip_of(r_ref) : 7'h00;
                rolls  <= rolls + ROLL_W'(1);
                if (w_ok) score <= w_score_nxt;
            end else if (w_ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dice_reader.md
Name: dice_reader

Overview:
Consumer side of the electronic dice. Watches the shared roll button and the dice `throw` bus, and waits for the roll to finish (button released, throw stable). It then latches the result and drives a 7-LED pip pattern. It also keeps a running score and roll count, and presents each result to downstream logic with a valid/ack handshake.

Parameters:
SETTLE_CYC, 4, consecutive cycles `throw` must stay unchanged after button release before the result is accepted (min 1)
SCORE_W, 8, width of the score accumulator
ROLL_W, 6, width of the roll counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
button  input  1  same roll button that drives the dice; high = rolling
throw  input  3  dice output value
ack  input  1  downstream accepts the current result
result  output  3  latched throw value
pips  output  7  LED pattern: bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR
valid  output  1  result/pips hold a new, unacknowledged result
error  output  1  latched result was outside 1..6
score  output  SCORE_W  sum of all valid results, saturating
rolls  output  ROLL_W  count of accepted results (valid or error), wrapping

Behaviour:
- Reset (async, any state): state=IDLE; result=0, pips=0, valid=0, error=0, score=0, rolls=0; settle counter=0.
- FSM states: IDLE, ROLLING, SETTLE, REPORT. All transitions and output updates are registered on the clk rising edge.
- IDLE: button=1 -> ROLLING. Otherwise stay.
- ROLLING: button=0 -> SETTLE, with counter=0 and the current throw captured as the reference value. Otherwise stay.
- SETTLE:
  - button=1 -> ROLLING. Priority over everything else.
  - throw != reference -> capture the new reference, counter=0.
  - Otherwise counter++. When counter reaches SETTLE_CYC-1 on a stable cycle -> REPORT.
  - Minimum latency from button fall to valid rising is SETTLE_CYC+1 cycles.
- Entry to REPORT, single cycle of updates:
  - result=reference; valid=1; rolls+=1, wrapping at 2^ROLL_W.
  - Reference in 1..6: error=0; pips per the table below; score+=reference, saturating at 2^SCORE_W-1 (never wraps).
  - Reference in {0,7}: error=1; pips=7'h00; score unchanged.
- Pip table: 1=7'h08, 2=7'h41, 3=7'h49, 4=7'h63, 5=7'h6B, 6=7'h77.
- REPORT:
  - result, pips, error, valid are held stable until ack=1.
  - ack=1 -> valid=0 next cycle, state=IDLE. result/pips/error keep their last value until the next REPORT.
  - button=1 while in REPORT without ack: stay in REPORT. The new roll is not tracked until the result is acknowledged; after ack, if button is still 1, the path is IDLE -> ROLLING on the next cycle.
  - ack=1 and button=1 in the same cycle: ack wins (-> IDLE).
- ack outside REPORT is ignored.
- Reset mid-operation discards any partial settle and any unacknowledged result.

Optional Feature:
Macro DICE_READER_DOUBLE_BONUS_EN.
- Defined:
  - Add a register holding the previous valid result, with reset value 0.
  - A valid result equal to the previous valid result adds 2x its value to score, saturating.
  - An error result clears the previous-result register to 0.
  - Add output port `bonus` (1 bit): high together with valid when the double was applied, cleared with valid.
- Not defined: no bonus logic, no `bonus` port; score adds 1x only.

Test Plan:
1. Reset, then button high 5 cycles, throw=3, button low, throw held at 3 -> valid=1 exactly SETTLE_CYC+1 cycles after the button fall; result=3, pips=7'h49, score=3, rolls=1, error=0.
2. After button low, throw changes 3->4 on settle cycle 2 and then holds -> counter restarts; valid asserts SETTLE_CYC+1 cycles after the change; result=4, pips=7'h63.
3. Button re-pressed during SETTLE -> back to ROLLING, no valid; a later release and settle on 6 -> result=6, pips=7'h77, rolls=1.
4. Settle on throw=7 -> error=1, pips=7'h00, score unchanged, rolls incremented. Hold ack=0 for 10 cycles -> outputs stable. ack=1 -> valid=0 next cycle.
5. Preload score to 254 via repeated rolls (SCORE_W=8), then a roll of 5 -> score=255 (saturated). Roll count wraps from 63 to 0.
6. Assert rst asynchronously mid-SETTLE and mid-REPORT -> all outputs 0 immediately, with no clock edge needed. With DICE_READER_DOUBLE_BONUS_EN: two consecutive rolls of 2 -> score 2 then 6, bonus=1 on the second roll.
